parity_frame_checker: RTL and testbench

//  Parametrised, clocked successor to the 4-input parity exercise. Accepts a

---
 rtl/parity_pkg.sv | 7 +
 rtl/xor_reduce.sv | 9 +
 rtl/parity_frame_checker.sv | 109 ++++++++++
 tb/tb_parity_frame_checker.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// parity_pkg: shared FSM state type and result-width helper for the parity frame checker
package parity_pkg;
  typedef enum logic {ACCUM, DONE} state_t;
  function automatic int words_w(input int frame_len);
    return $clog2(frame_len + 1);
  endfunction
endpackage

// File: rtl/xor_reduce.sv
// xor_reduce: combinational parity of one word (data_i -> parity_o)
module xor_reduce #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] data_i,
  output logic             parity_o
);
  assign parity_o = ^data_i;
endmodule

// File: rtl/parity_frame_checker.sv
// parity_frame_checker: XOR-accumulates valid/ready words into frames, emits parity + word count
// Ports: clk, reset (sync, active-high); in_valid/in_ready/in_data/in_last/odd_mode input stream;
// out_valid/out_ready/out_parity/out_words result; exp_parity/err_count/frame_count only with
// PARITY_ERROR_COUNT_EN defined.
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  input  logic                           in_last,
  input  logic                           odd_mode,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_parity,
`ifdef PARITY_ERROR_COUNT_EN
  output logic [words_w(FRAME_LEN)-1:0]  out_words,
  input  logic                           exp_parity,
  output logic [CNT_W-1:0]               err_count,
  output logic [CNT_W-1:0]               frame_count
`else
  output logic [words_w(FRAME_LEN)-1:0]  out_words
`endif
);
  localparam int CW = words_w(FRAME_LEN);
  state_t        state_q, state_d;
  logic          acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic          par_q, par_d;
  logic [CW-1:0] words_q, words_d;
  logic          word_par, accept, hs, mode_cur, acc_nx, close;
  xor_reduce #(.WIDTH(WIDTH)) u_xor (.data_i(in_data), .parity_o(word_par));
  assign in_ready  = state_q == ACCUM;
  assign out_valid = state_q == DONE;
  assign accept    = in_valid & in_ready;
  assign hs        = out_valid & out_ready;
  // mode is taken from the first word of a frame, the latched copy thereafter
  assign mode_cur  = cnt_q == '0 ? odd_mode : mode_q;
  assign acc_nx    = acc_q ^ word_par;
  // in_last on the final allowed word still closes just one frame
  assign close     = in_last | (cnt_q == CW'(FRAME_LEN - 1));
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    par_d   = par_q;
    words_d = words_q;
    if (accept) begin
      acc_d  = acc_nx;
      cnt_d  = cnt_q + CW'(1);
      mode_d = mode_cur;
      if (close) begin
        state_d = DONE;
        par_d   = acc_nx ^ mode_cur;
        words_d = cnt_q + CW'(1);
      end
    end
    if (hs) begin
      state_d = ACCUM;
      acc_d   = 1'b0;
      cnt_d   = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCUM;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      par_q   <= 1'b0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      par_q   <= par_d;
      words_q <= words_d;
    end
  end
  assign out_parity = par_q;
  assign out_words  = words_q;
`ifdef PARITY_ERROR_COUNT_EN
  logic [CNT_W-1:0] err_q, err_d, frm_q, frm_d;
  always_comb begin
    frm_d = hs && !(&frm_q) ? frm_q + CNT_W'(1) : frm_q;
    err_d = hs && (exp_parity != par_q) && !(&err_q) ? err_q + CNT_W'(1) : err_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= '0;
      frm_q <= '0;
    end else begin
      err_q <= err_d;
      frm_q <= frm_d;
    end
  end
  assign err_count   = err_q;
  assign frame_count = frm_q;
`endif
endmodule

// File: tb/tb_parity_frame_checker.sv
// tb_parity_frame_checker: directed self-checking bench for parity_frame_checker (W=4, L=4)
module tb_parity_frame_checker;
  import parity_pkg::*;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       odd_mode = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_parity;
  logic [words_w(4)-1:0] out_words;
  int checks = 0;
  int errors = 0;
`ifdef PARITY_ERROR_COUNT_EN
  logic       exp_parity = 1'b0;
  logic [1:0] err_count, frame_count;
`endif
  parity_frame_checker #(.WIDTH(4), .FRAME_LEN(4), .CNT_W(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .odd_mode(odd_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_parity(out_parity),
`ifdef PARITY_ERROR_COUNT_EN
    .out_words(out_words),
    .exp_parity(exp_parity), .err_count(err_count), .frame_count(frame_count)
`else
    .out_words(out_words)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [3:0] d, input logic last, input logic mode);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    odd_mode = mode;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    odd_mode = 1'b0;
  endtask
  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask
  task automatic check_result(input string tag, input logic par, input logic [2:0] words);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_parity"}, 32'(out_parity), 32'(par));
    check({tag, "_words"}, 32'(out_words), 32'(words));
  endtask
  initial begin
    step();
    step();
    reset = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_parity", 32'(out_parity), 32'd0);
    check("rst_words", 32'(out_words), 32'd0);
`ifdef PARITY_ERROR_COUNT_EN
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_frames", 32'(frame_count), 32'd0);
`endif
    send(4'b0001, 1'b0, 1'b0);
    send(4'b0011, 1'b0, 1'b0);
    send(4'b0000, 1'b0, 1'b0);
    check("t1_not_early", 32'(out_valid), 32'd0);
    send(4'b1111, 1'b0, 1'b0);
    check_result("t1", 1'b1, 3'd4);
    step();
    check_result("t1_hold", 1'b1, 3'd4);
    handshake();
    check("t1_in_ready_after", 32'(in_ready), 32'd1);
    check("t1_out_valid_after", 32'(out_valid), 32'd0);
    send(4'b0001, 1'b0, 1'b1);
    send(4'b0011, 1'b0, 1'b0);
    send(4'b0000, 1'b0, 1'b0);
    send(4'b1111, 1'b0, 1'b0);
    check_result("t2", 1'b0, 3'd4);
    handshake();
    send(4'b0111, 1'b0, 1'b0);
    send(4'b0001, 1'b1, 1'b0);
    check_result("t3", 1'b0, 3'd2);
    in_valid = 1'b1;
    in_data  = 4'b0001;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_result("t4_stall", 1'b0, 3'd2);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    handshake();
    check("t4_in_ready", 32'(in_ready), 32'd1);
    check("t4_out_valid", 32'(out_valid), 32'd0);
    send(4'b0001, 1'b1, 1'b0);
    check_result("t4_next", 1'b1, 3'd1);
    handshake();
    send(4'b1000, 1'b0, 1'b0);
    send(4'b1000, 1'b0, 1'b0);
    send(4'b1000, 1'b0, 1'b0);
    send(4'b1000, 1'b1, 1'b1);
    check_result("last_at_len", 1'b0, 3'd4);
    handshake();
    check("last_at_len_one_frame", 32'(out_valid), 32'd0);
    send(4'b0001, 1'b0, 1'b0);
    send(4'b0001, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_in_ready", 32'(in_ready), 32'd1);
    check("t5_out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 4; i++) send(4'b1000, 1'b0, 1'b0);
    check_result("t5", 1'b0, 3'd4);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    check("idle_out_ready_ignored", 32'(out_valid), 32'd0);
`ifdef PARITY_ERROR_COUNT_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int f = 0; f < 5; f++) begin
      send(4'b0001, 1'b1, 1'b0);
      check_result("t6", 1'b1, 3'd1);
      exp_parity = f == 4;
      handshake();
      if (f == 0) begin
        check("t6_frames_1", 32'(frame_count), 32'd1);
        check("t6_err_1", 32'(err_count), 32'd1);
      end
    end
    check("t6_frames_sat", 32'(frame_count), 32'd3);
    check("t6_err_sat", 32'(err_count), 32'd3);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
